tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
Parametrised multi-channel tick generator and next-generation system timebase. Produces N_CH independent single-cycle tick strobes and matching toggle (square) outputs from clk. Each channel's divisor is runtime-programmable, with glitch-free or immediate update. Global enable, per-channel enable and a synchronous phase-align restart are provided. Feeds display refresh, banner scroll and any other rate-based consumers.

Parameters:
N_CH, 2, number of independent channels (1..16)
CNT_W, 26, counter/divisor width per channel
DIV_INIT, {26'd50000000, 26'd208333}, packed N_CH*CNT_W reset divisors; channel i at bits [i*CNT_W +: CNT_W]

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
en  in  1  global enable; 0 freezes all channels
ch_en  in  N_CH  per-channel enable mask
sync  in  1  one-cycle pulse: restart all channel counters phase-aligned
cfg_we  in  1  divisor write strobe
cfg_ch  in  4  channel select for write and readback
cfg_div  in  CNT_W  new divisor value
cfg_imm  in  1  1 = apply the write immediately (restart channel); 0 = apply at the next wrap
cfg_rdata  out  CNT_W  active divisor of cfg_ch (combinational; 0 if cfg_ch >= N_CH)
tick  out  N_CH  registered one-cycle strobes
sq  out  N_CH  registered toggle outputs; toggle on each tick (period 2*D)

Behaviour:
- Per channel i state:
  - div_act[i]: active divisor.
  - div_pend[i]: pending divisor.
  - pend_v[i]: pending-valid flag.
  - cnt[i]: down-counter.
- Effective divisor D = max(div_act, 1). Values 0 and 1 both mean tick every cycle.
- Reset (rst=0 at a posedge):
  - div_act = div_pend = DIV_INIT slice; pend_v = 0.
  - cnt = D-1; tick = 0; sq = 0.
  - Reset mid-operation discards pending writes.
- Counting applies when en=1 and ch_en[i]=1:
  - If cnt != 0: cnt <= cnt-1 and tick[i] <= 0.
  - If cnt == 0: tick[i] <= 1, sq[i] <= ~sq[i], and the channel reloads.
  - Reload: if pend_v, div_act <= div_pend and pend_v <= 0. Then cnt <= (new D)-1.
- Timing:
  - Tick period is exactly D clk cycles.
  - First tick is high in the cycle after the D-th rising edge following reset release (or restart).
  - The tick is one cycle wide. D=1 gives tick held high continuously and sq toggling every cycle.
- ch_en[i]=0 (with en=1):
  - cnt[i] <= D-1 (pending applied); tick[i] <= 0; sq[i] holds.
  - Re-enabling starts a full period.
- en=0: all cnt, sq and div_act hold; tick <= 0. Config writes are still accepted.
- sync=1 (en is don't-care):
  - Every channel applies pending, cnt <= D-1, tick <= 0, sq <= 0.
  - Channels with equal D then tick on the same cycles.
- Config write (cfg_we=1, cfg_ch < N_CH):
  - cfg_imm=0: div_pend <= cfg_div and pend_v <= 1. A later write before the wrap overwrites it (last write wins).
  - cfg_imm=1: div_act <= cfg_div, pend_v <= 0, cnt <= max(cfg_div,1)-1, tick <= 0. sq holds.
  - cfg_ch >= N_CH: write ignored, no side effects.
- Simultaneous events:
  - Priority: rst > sync > cfg_imm write > enables > count.
  - Deferred write on the wrap edge of the same channel: the new value is used for that reload (bypass).
  - sync together with a deferred write: the written value is applied by the sync.
- Arithmetic:
  - Counters are unsigned CNT_W. No overflow is possible since cnt <= D-1.
  - cfg_rdata returns div_act, not div_pend.

Test Plan:
- Reset, DIV_INIT={8,3}, en=1, ch_en=11: tick[0] pulses on cycles 3,6,9… and tick[1] on 8,16… after release; sq[0] toggles each tick; all outputs are 0 while rst=0.
- Ch0 D=3, write cfg_div=5 with cfg_imm=0 at cycle 4: the pulse at cycle 6 is still present, the next pulses fall on 11,16; cfg_rdata reads 3 until cycle 6, then 5.
- Ch0 D=10, cfg_imm=1 write of 4 at cycle 5: no tick at cycle 10, ticks at 9,13; also write cfg_div=0 → tick held high continuously.
- Ch0 D=4, ch1 D=6, pulse sync at cycle 7: sq=00 next cycle; ticks at cycles 11/13 (4 and 6 after sync); with both set to D=4, ticks coincide.
- en=0 for 5 cycles mid-period: the tick schedule shifts exactly 5 cycles later; ch_en[1]=0 then 1 gives the first tick a full D cycles after re-enable; a write to cfg_ch=3 leaves state unchanged.
- Assert rst during a pending write: after release, div_act equals the DIV_INIT value and the pending value is never applied.

Source files
------------

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: multi-channel tick generator / system timebase.
//
// Each of N_CH channels runs a down-counter that reloads from its own
// runtime-programmable divisor D (0 and 1 both mean "every cycle") and emits a
// registered one-cycle strobe every D cycles plus a square wave that toggles on
// each strobe (period 2*D). Divisor writes either take effect immediately
// (restarting the channel) or are parked and picked up at the next wrap, which
// keeps the output period glitch-free.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-low reset
//   en         global enable; 0 freezes every channel (tick forced low)
//   ch_en      per-channel enable; a disabled channel is held at the start of a period
//   sync       one-cycle pulse restarting all channels phase-aligned, sq cleared
//   cfg_we     divisor write strobe
//   cfg_ch     channel select for writes and for cfg_rdata
//   cfg_div    divisor value to write
//   cfg_imm    1 = apply write now and restart channel, 0 = apply at next wrap
//   cfg_rdata  active divisor of cfg_ch (combinational, 0 for cfg_ch >= N_CH)
//   tick       registered one-cycle strobes, one per channel
//   sq         registered square outputs, toggling on each tick
module tick_gen_multi #(
    parameter int unsigned           N_CH     = 2,
    parameter int unsigned           CNT_W    = 26,
    parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {26'd50000000, 26'd208333}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_imm,
    output logic [CNT_W-1:0] cfg_rdata,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
);

    // Counter start value for a divisor: max(div,1)-1.
    function automatic logic [CNT_W-1:0] reload_cnt(input logic [CNT_W-1:0] div);
        reload_cnt = (div == '0) ? '0 : div - CNT_W'(1);
    endfunction

    logic [N_CH-1:0][CNT_W-1:0] div_act_q,  div_act_d;
    logic [N_CH-1:0][CNT_W-1:0] div_pend_q, div_pend_d;
    logic [N_CH-1:0]            pend_v_q,   pend_v_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q,      cnt_d;
    logic [N_CH-1:0]            tick_q,     tick_d;
    logic [N_CH-1:0]            sq_q,       sq_d;

    logic [N_CH-1:0]            wr_hit;
    logic [N_CH-1:0][CNT_W-1:0] next_div;

    // Write decode and the divisor a reload would adopt this cycle. A deferred
    // write landing on the wrap edge bypasses the pending register so it is used
    // by that very reload.
    always_comb begin
        wr_hit   = '0;
        next_div = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = cfg_we && (cfg_ch == 4'(i));
            if (wr_hit[i]) begin
                next_div[i] = cfg_div;
            end else if (pend_v_q[i]) begin
                next_div[i] = div_pend_q[i];
            end else begin
                next_div[i] = div_act_q[i];
            end
        end
    end

    // Next-state logic, priority: sync > immediate write > enables > count.
    always_comb begin
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;
        cnt_d      = cnt_q;
        tick_d     = '0;
        sq_d       = sq_q;
        for (int i = 0; i < N_CH; i++) begin
            if (sync) begin
                // Restart everything phase-aligned; a write in the same cycle
                // (of either kind) is what the restart adopts.
                div_act_d[i] = next_div[i];
                if (wr_hit[i]) begin
                    div_pend_d[i] = cfg_div;
                end
                pend_v_d[i] = 1'b0;
                cnt_d[i]    = reload_cnt(next_div[i]);
                sq_d[i]     = 1'b0;
            end else if (wr_hit[i] && cfg_imm) begin
                div_act_d[i] = cfg_div;
                pend_v_d[i]  = 1'b0;
                cnt_d[i]     = reload_cnt(cfg_div);
            end else begin
                if (wr_hit[i]) begin
                    div_pend_d[i] = cfg_div;
                    pend_v_d[i]   = 1'b1;
                end
                if (en) begin
                    if (!ch_en[i]) begin
                        // Park the channel at the top of a fresh period.
                        div_act_d[i] = next_div[i];
                        pend_v_d[i]  = 1'b0;
                        cnt_d[i]     = reload_cnt(next_div[i]);
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else begin
                        tick_d[i]    = 1'b1;
                        sq_d[i]      = ~sq_q[i];
                        div_act_d[i] = next_div[i];
                        pend_v_d[i]  = 1'b0;
                        cnt_d[i]     = reload_cnt(next_div[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                div_act_q[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
                div_pend_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
                cnt_q[i]      <= reload_cnt(DIV_INIT[i*CNT_W +: CNT_W]);
            end
            pend_v_q <= '0;
            tick_q   <= '0;
            sq_q     <= '0;
        end else begin
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_v_q   <= pend_v_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
        end
    end

    // Readback of the active (not pending) divisor; unmapped channels read 0.
    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == 4'(i)) begin
                cfg_rdata = div_act_q[i];
            end
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi with DIV_INIT = {8, 3} (ch0 = 3, ch1 = 8).
// A schedule-based model (absolute due-cycle per channel) is compared against
// the DUT on every negedge; directed scenarios add literal expectations.
module tb_tick_gen_multi;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = 26;
    localparam logic [N_CH*CNT_W-1:0] INIT = {26'd8, 26'd3};

    logic             clk;
    logic             rst;
    logic             en;
    logic [N_CH-1:0]  ch_en;
    logic             sync;
    logic             cfg_we;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_imm;
    logic [CNT_W-1:0] cfg_rdata;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  sq;

    tick_gen_multi #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT (INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_imm   (cfg_imm),
        .cfg_rdata (cfg_rdata),
        .tick      (tick),
        .sq        (sq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model: each channel knows the edge its next tick lands on
    logic [CNT_W-1:0] m_act  [N_CH];
    logic [CNT_W-1:0] m_pend [N_CH];
    bit               m_pv   [N_CH];
    longint           m_due  [N_CH];
    logic [N_CH-1:0]  m_tick;
    logic [N_CH-1:0]  m_sq;
    bit               m_valid = 1'b0;
    longint           edge_n  = 0;
    bit               m_hit;
    logic [CNT_W-1:0] m_val;

    function automatic longint deff(input logic [CNT_W-1:0] v);
        return (v == 0) ? 1 : longint'(v);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            m_hit = cfg_we && (int'(cfg_ch) == i);
            m_val = m_hit ? cfg_div : (m_pv[i] ? m_pend[i] : m_act[i]);
            if (!rst) begin
                m_act[i]  = INIT[i*CNT_W +: CNT_W];
                m_pv[i]   = 1'b0;
                m_due[i]  = edge_n + deff(m_act[i]);
                m_tick[i] = 1'b0;
                m_sq[i]   = 1'b0;
                m_valid   = 1'b1;
            end else if (sync) begin
                m_act[i]  = m_val;
                m_pv[i]   = 1'b0;
                m_due[i]  = edge_n + deff(m_val);
                m_tick[i] = 1'b0;
                m_sq[i]   = 1'b0;
            end else if (m_hit && cfg_imm) begin
                m_act[i]  = cfg_div;
                m_pv[i]   = 1'b0;
                m_due[i]  = edge_n + deff(cfg_div);
                m_tick[i] = 1'b0;
            end else begin
                if (m_hit) begin
                    m_pend[i] = cfg_div;
                    m_pv[i]   = 1'b1;
                end
                m_tick[i] = 1'b0;
                if (!en) begin
                    m_due[i] = m_due[i] + 1;  // frozen cycle pushes the schedule out
                end else if (!ch_en[i]) begin
                    m_act[i] = m_val;
                    m_pv[i]  = 1'b0;
                    m_due[i] = edge_n + deff(m_val);
                end else if (edge_n == m_due[i]) begin
                    m_tick[i] = 1'b1;
                    m_sq[i]   = ~m_sq[i];
                    m_act[i]  = m_val;
                    m_pv[i]   = 1'b0;
                    m_due[i]  = edge_n + deff(m_val);
                end
            end
        end
        edge_n++;
    end

    // ---------------- compare process
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_tick", 64'(tick), 64'(m_tick));
            chk("model_sq", 64'(sq), 64'(m_sq));
            if (int'(cfg_ch) < N_CH) chk("model_rdata", 64'(cfg_rdata), 64'(m_act[int'(cfg_ch)]));
            else chk("model_rdata_oob", 64'(cfg_rdata), 64'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic wr(input int ch, input int div, input bit imm);
        cfg_we  = 1'b1;
        cfg_ch  = 4'(ch);
        cfg_div = CNT_W'(div);
        cfg_imm = imm;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; ch_en = 2'b11; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = 4'd0; cfg_div = '0; cfg_imm = 1'b0;

        // Reset and free-running D=3 / D=8.
        repeat (3) begin
            step();
            chk("rst_tick", 64'(tick), 64'(0));
            chk("rst_sq", 64'(sq), 64'(0));
        end
        rst = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("s1_tick0", 64'(tick[0]), 64'(c % 3 == 0));
            chk("s1_tick1", 64'(tick[1]), 64'(c % 8 == 0));
            chk("s1_sq0", 64'(sq[0]), 64'((c / 3) % 2));
        end

        // Deferred write of 5 at cycle 4.
        rst = 1'b0; step(); rst = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            if (c == 4) wr(0, 5, 1'b0);
            else cfg_we = 1'b0;
            step();
            chk("s2_tick0", 64'(tick[0]), 64'(c == 3 || c == 6 || c == 11 || c == 16));
            chk("s2_rdata", 64'(cfg_rdata), 64'((c < 6) ? 3 : 5));
        end
        cfg_we = 1'b0;

        // Immediate writes: D=10, then 4 at cycle 5, then 0.
        wr(0, 10, 1'b1); step(); cfg_we = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) wr(0, 4, 1'b1);
            else cfg_we = 1'b0;
            step();
            chk("s3_tick0", 64'(tick[0]), 64'(c == 9 || c == 13));
        end
        wr(0, 0, 1'b1); step(); cfg_we = 1'b0;
        chk("s3_imm0_tick", 64'(tick[0]), 64'(0));
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("s3_d0_tick", 64'(tick[0]), 64'(1));
        end

        // Sync with D=4 / D=6 at cycle 7.
        wr(0, 4, 1'b1); step();
        wr(1, 6, 1'b1); step();
        cfg_we = 1'b0; cfg_ch = 4'd0;
        for (int c = 1; c <= 14; c++) begin
            sync = (c == 7);
            step();
            if (c == 7) begin
                chk("s4_sync_sq", 64'(sq), 64'(0));
                chk("s4_sync_tick", 64'(tick), 64'(0));
            end
            if (c >= 7) begin
                chk("s4_tick0", 64'(tick[0]), 64'(c == 11));
                chk("s4_tick1", 64'(tick[1]), 64'(c == 13));
            end
        end
        // Deferred write together with sync: the sync adopts it.
        wr(1, 4, 1'b0); sync = 1'b1; step();
        cfg_we = 1'b0; sync = 1'b0; cfg_ch = 4'd1;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("s4_align", 64'(tick), 64'((c % 4 == 0) ? 3 : 0));
        end
        cfg_ch = 4'd0;

        // Global enable low for 5 cycles.
        sync = 1'b1; step(); sync = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            en = !(c >= 5 && c <= 9);
            step();
            chk("s5_en_tick", 64'(tick), 64'((c == 4 || c == 13 || c == 17) ? 3 : 0));
        end
        en = 1'b1;

        // ch_en[1] low for two cycles, then an out-of-range write.
        sync = 1'b1; step(); sync = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            ch_en = (c == 2 || c == 3) ? 2'b01 : 2'b11;
            if (c == 13) wr(3, 1, 1'b1);
            else begin
                cfg_we = 1'b0;
                cfg_ch = 4'd0;
            end
            step();
            chk("s5_ch0", 64'(tick[0]), 64'(c % 4 == 0));
            chk("s5_ch1", 64'(tick[1]), 64'(c == 7 || c == 11 || c == 15));
            if (c == 13) chk("s5_oob_rdata", 64'(cfg_rdata), 64'(0));
            if (c == 14) chk("s5_rdata_keep", 64'(cfg_rdata), 64'(4));
        end
        cfg_we = 1'b0; ch_en = 2'b11;

        // Reset discards a pending write.
        wr(0, 7, 1'b0); step(); cfg_we = 1'b0;
        rst = 1'b0; step(); rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("s6_tick0", 64'(tick[0]), 64'(c % 3 == 0));
            chk("s6_rdata", 64'(cfg_rdata), 64'(3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
